dispensador_agua: RTL and testbench
===================================

Name: dispensador_agua

Overview:
- Consumer-side controller for the coffee machine water reservoir.
- Accepts short/long drink requests and drives the reservoir's `Usar` line one water unit per clock.
- Reads `TemAgua`, `TempoDeAgua` and `HouveRefill` back from the reservoir.
- When water is insufficient, issues a `Refill` pulse and resumes the pending drink once the refill is confirmed.

Parameters:
- CAPACIDADE, 10, full reservoir level in water units (reservoir reload value).
- DOSE_CURTO, 2, water units for a short coffee.
- DOSE_LONGO, 4, water units for a long coffee.
- REFILL_HOLD, 2, cycles `Refill` is held high before its falling edge.
- REFILL_TIMEOUT, 8, cycles allowed in REFILL_WAIT for confirmation.

Ports:
- Clock  in  1  system clock, all state updates on posedge.
- Reset  in  1  asynchronous, active-high reset.
- PedidoCurto  in  1  short-drink request, sampled high for one cycle.
- PedidoLongo  in  1  long-drink request, sampled high for one cycle.
- TemAgua  in  1  reservoir non-empty flag.
- TempoDeAgua  in  4  reservoir level, unsigned.
- HouveRefill  in  1  reservoir refill-occurred flag.
- Usar  out  1  consume one water unit this cycle.
- Refill  out  1  refill request; the reservoir acts on its falling edge.
- Ocupado  out  1  high in every state except IDLE.
- Pronto  out  1  one-cycle pulse when a drink completes.
- Erro  out  1  one-cycle pulse on abort or refill timeout.
- UnidadesServidas  out  4  units poured for the current drink.

Behaviour:
- Interface decision: one clock, `Clock`; reset `Reset`, asynchronous and active-high.
- Reset values: all outputs 0, state IDLE, latched dose 0, counters 0.
- Registered outputs: every output is registered; none is combinational from inputs.
- FSM states: IDLE, CHECK, POUR, DONE, REFILL_REQ, REFILL_WAIT.
- IDLE:
  - On `PedidoCurto` or `PedidoLongo`, latch the dose and go to CHECK.
  - If both are high in the same cycle, the short request wins and the long one is dropped.
- CHECK (1 cycle):
  - If `TempoDeAgua >= dose`, go to POUR.
  - Otherwise go to REFILL_REQ; the pending dose is kept.
- POUR:
  - `Usar`=1 every cycle; `UnidadesServidas` increments each cycle.
  - When the count reaches the dose, `Usar`=0 on the next cycle and go to DONE.
  - Latency: a dose of D gives exactly D cycles of `Usar`=1.
  - If `TemAgua`=0 is sampled while count < dose: `Usar`=0, `Erro` pulse, go to IDLE, clear `UnidadesServidas`.
- DONE (1 cycle): `Pronto`=1; `UnidadesServidas` holds its final value until the next CHECK clears it. Go to IDLE.
- REFILL_REQ: `Refill`=1 for REFILL_HOLD cycles, then `Refill`=0, then go to REFILL_WAIT.
- REFILL_WAIT:
  - Confirmation is `HouveRefill`=1 or `TempoDeAgua`==CAPACIDADE. On confirmation, go to CHECK and retry the latched dose.
  - If REFILL_TIMEOUT cycles pass without confirmation: `Erro` pulse, go to IDLE, drop the dose.
  - A confirmation in the same cycle as the timeout counts as success.
- Requests while busy: any request arriving while `Ocupado`=1 is ignored (but see optional feature).
- Width rules:
  - Dose comparison is 4-bit unsigned.
  - Counter widths are sized so that DOSE_LONGO, REFILL_HOLD and REFILL_TIMEOUT never wrap.
  - Elaboration must fail if DOSE_LONGO > CAPACIDADE.
- Reset mid-operation: returns to IDLE within the same cycle (asynchronous). `Usar` and `Refill` drop immediately; a dropped `Refill` during REFILL_REQ may cause one reservoir refill, which is acceptable.

Optional Feature:
- Macro: PEDIDO_FILA_EN.
- Defined:
  - A one-deep pending-request register captures the first request that arrives while `Ocupado`=1; later requests are ignored while it is full.
  - After DONE or an `Erro` return to IDLE, a pending request is consumed the next cycle exactly as a fresh request.
  - A short request beats a long one in the same cycle.
- Undefined: requests while busy are discarded; behaviour is otherwise identical.

Decomposition:
- Shared package `maquina_cafe_pkg`:
  - state enum `estado_disp_t`;
  - constants for CAPACIDADE, DOSE_CURTO and DOSE_LONGO, so the reservoir and the dispenser use the same values;
  - the 4-bit level width constant.
- One sub-module, `temporizador_refill`: a loadable down-counter with `load`, `value` and `zero` ports, used for both REFILL_HOLD and REFILL_TIMEOUT.

Test Plan:
- Level 10, `PedidoCurto` pulse -> `Usar` high for exactly 2 cycles; `Pronto` 1 cycle later; `UnidadesServidas`=2; reservoir reaches 8.
- Level 3, `PedidoLongo` -> `Refill` high for 2 cycles then low; `HouveRefill` returned -> CHECK then 4 cycles of `Usar`; `Pronto`; level 6.
- Level 1, `PedidoLongo`, reservoir never refills -> `Erro` pulse 8 cycles after entering REFILL_WAIT; `Usar` never asserted; IDLE.
- `PedidoCurto` and `PedidoLongo` high in the same cycle, level 10 -> dose 2 only. With PEDIDO_FILA_EN: a `PedidoLongo` during POUR is served next, for 6 units total.
- `Reset` asserted mid-POUR after 1 unit -> `Usar`=0 and `Ocupado`=0 immediately; a new `PedidoCurto` after release pours 2 full units.
- `TemAgua` forced to 0 during POUR with dose 4 -> `Erro` pulse, `Usar` drops, `UnidadesServidas` clears, state IDLE.

Source files
------------

// File: rtl/maquina_cafe_pkg.sv
// rtl/maquina_cafe_pkg.sv - shared constants and state type for the coffee machine water path
// Contents: reservoir level width, default capacity and doses shared by the
// reservoir and the dispenser, and the dispenser FSM state enum.
package maquina_cafe_pkg;

    // Reservoir level and poured-unit counters are carried on this many bits.
    localparam int AGUA_NIVEL_W = 4;

    // Defaults shared by the reservoir (reload value) and the dispenser (doses).
    localparam int AGUA_CAPACIDADE = 10;
    localparam int AGUA_DOSE_CURTO = 2;
    localparam int AGUA_DOSE_LONGO = 4;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        CHECK       = 3'd1,
        POUR        = 3'd2,
        DONE        = 3'd3,
        REFILL_REQ  = 3'd4,
        REFILL_WAIT = 3'd5
    } estado_disp_t;

    // Bits needed to hold any value in 0..max_val.
    function automatic int largura_contador(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/dispensador_agua_if.sv
// rtl/dispensador_agua_if.sv - dispenser <-> requester/reservoir signal bundle
// master: drives PedidoCurto, PedidoLongo, TemAgua, TempoDeAgua, HouveRefill and
//         observes Usar, Refill, Ocupado, Pronto, Erro, UnidadesServidas.
// slave:  the dispenser side, with the directions reversed.
interface dispensador_agua_if;
    import maquina_cafe_pkg::*;

    logic                    PedidoCurto;
    logic                    PedidoLongo;
    logic                    TemAgua;
    logic [AGUA_NIVEL_W-1:0] TempoDeAgua;
    logic                    HouveRefill;

    logic                    Usar;
    logic                    Refill;
    logic                    Ocupado;
    logic                    Pronto;
    logic                    Erro;
    logic [AGUA_NIVEL_W-1:0] UnidadesServidas;

    modport master (
        output PedidoCurto, PedidoLongo, TemAgua, TempoDeAgua, HouveRefill,
        input  Usar, Refill, Ocupado, Pronto, Erro, UnidadesServidas
    );

    modport slave (
        input  PedidoCurto, PedidoLongo, TemAgua, TempoDeAgua, HouveRefill,
        output Usar, Refill, Ocupado, Pronto, Erro, UnidadesServidas
    );

endinterface

// File: rtl/dispensador_agua_temporizador.sv
// rtl/dispensador_agua_temporizador.sv - loadable down-counter for refill hold and timeout
// Ports: Clock, Reset (async, active-high); i_load/i_value reload the counter,
// o_zero is high while the count is zero. The count saturates at zero.
module temporizador_refill #(
    parameter int W = 4
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         i_load,
    input  logic [W-1:0] i_value,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (r_count != '0) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/dispensador_agua.sv
// rtl/dispensador_agua.sv - water dispenser controller for the coffee machine reservoir
// Ports: Clock, Reset (async, active-high); bus (slave modport) carries the
// short/long drink requests, the reservoir status (TemAgua, TempoDeAgua,
// HouveRefill) and the registered outputs Usar, Refill, Ocupado, Pronto, Erro
// and UnidadesServidas.
// Build option: PEDIDO_FILA_EN adds a one-deep register holding the first
// request made while busy; it is served as soon as the FSM is back in IDLE.
module dispensador_agua
    import maquina_cafe_pkg::*;
#(
    parameter int CAPACIDADE     = AGUA_CAPACIDADE,
    parameter int DOSE_CURTO     = AGUA_DOSE_CURTO,
    parameter int DOSE_LONGO     = AGUA_DOSE_LONGO,
    parameter int REFILL_HOLD    = 2,
    parameter int REFILL_TIMEOUT = 8
) (
    input  logic              Clock,
    input  logic              Reset,
    dispensador_agua_if.slave bus
);

    // One timer serves both the hold and the timeout, so size it for the larger.
    localparam int TMR_MAX = (REFILL_HOLD > REFILL_TIMEOUT) ? REFILL_HOLD : REFILL_TIMEOUT;
    localparam int TMR_W   = largura_contador(TMR_MAX);

    localparam logic [AGUA_NIVEL_W-1:0] C_CAP   = AGUA_NIVEL_W'(CAPACIDADE);
    localparam logic [AGUA_NIVEL_W-1:0] C_CURTO = AGUA_NIVEL_W'(DOSE_CURTO);
    localparam logic [AGUA_NIVEL_W-1:0] C_LONGO = AGUA_NIVEL_W'(DOSE_LONGO);

    // The timer is loaded on the entry edge and the exit is taken on the edge
    // where it reads zero, hence the minus one.
    localparam logic [TMR_W-1:0] C_HOLD_LOAD = TMR_W'(REFILL_HOLD - 1);
    localparam logic [TMR_W-1:0] C_TMO_LOAD  = TMR_W'(REFILL_TIMEOUT - 1);

    generate
        if (DOSE_LONGO > CAPACIDADE) begin : g_chk_dose
            $error("dispensador_agua: DOSE_LONGO larger than CAPACIDADE");
        end
        if (CAPACIDADE >= (1 << AGUA_NIVEL_W)) begin : g_chk_cap
            $error("dispensador_agua: CAPACIDADE does not fit the level width");
        end
        if (DOSE_CURTO < 1 || DOSE_LONGO < 1) begin : g_chk_dose_min
            $error("dispensador_agua: doses must be at least one unit");
        end
        if (REFILL_HOLD < 1 || REFILL_TIMEOUT < 1) begin : g_chk_tmr
            $error("dispensador_agua: refill hold and timeout must be at least one cycle");
        end
    endgenerate

    estado_disp_t            r_estado;
    logic [AGUA_NIVEL_W-1:0] r_dose;
    logic [AGUA_NIVEL_W-1:0] r_unidades;
    logic                    r_usar;
    logic                    r_refill;
    logic                    r_ocupado;
    logic                    r_pronto;
    logic                    r_erro;

    estado_disp_t            w_estado_nxt;
    logic [AGUA_NIVEL_W-1:0] w_dose_nxt;
    logic [AGUA_NIVEL_W-1:0] w_unid_nxt;
    logic [AGUA_NIVEL_W-1:0] w_unid_inc;
    logic                    w_usar_nxt;
    logic                    w_refill_nxt;
    logic                    w_ocupado_nxt;
    logic                    w_pronto_nxt;
    logic                    w_erro_nxt;

    logic                    w_tmr_load;
    logic [TMR_W-1:0]        w_tmr_value;
    logic                    w_tmr_zero;

    // Request seen by the FSM in IDLE: valid flag and which dose it asks for.
    logic                    w_req_valid;
    logic                    w_req_longo;

`ifdef PEDIDO_FILA_EN
    logic r_pend_valid;
    logic r_pend_longo;

    // A waiting request is always served before a fresh one in IDLE.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_pend_valid <= 1'b0;
            r_pend_longo <= 1'b0;
        end else if (r_estado == IDLE && r_pend_valid) begin
            r_pend_valid <= 1'b0;
        end else if (r_ocupado && !r_pend_valid && (bus.PedidoCurto || bus.PedidoLongo)) begin
            r_pend_valid <= 1'b1;
            r_pend_longo <= ~bus.PedidoCurto;
        end
    end

    assign w_req_valid = r_pend_valid | bus.PedidoCurto | bus.PedidoLongo;
    assign w_req_longo = r_pend_valid ? r_pend_longo : ~bus.PedidoCurto;
`else
    assign w_req_valid = bus.PedidoCurto | bus.PedidoLongo;
    // Short wins when both arrive together.
    assign w_req_longo = ~bus.PedidoCurto;
`endif

    temporizador_refill #(
        .W (TMR_W)
    ) u_temporizador (
        .Clock   (Clock),
        .Reset   (Reset),
        .i_load  (w_tmr_load),
        .i_value (w_tmr_value),
        .o_zero  (w_tmr_zero)
    );

    assign w_unid_inc = r_unidades + AGUA_NIVEL_W'(1);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_estado   <= IDLE;
            r_dose     <= '0;
            r_unidades <= '0;
            r_usar     <= 1'b0;
            r_refill   <= 1'b0;
            r_ocupado  <= 1'b0;
            r_pronto   <= 1'b0;
            r_erro     <= 1'b0;
        end else begin
            r_estado   <= w_estado_nxt;
            r_dose     <= w_dose_nxt;
            r_unidades <= w_unid_nxt;
            r_usar     <= w_usar_nxt;
            r_refill   <= w_refill_nxt;
            r_ocupado  <= w_ocupado_nxt;
            r_pronto   <= w_pronto_nxt;
            r_erro     <= w_erro_nxt;
        end
    end

    // Outputs are computed for the next state and registered, so each output
    // is valid for exactly the cycles spent in the state that owns it.
    always_comb begin
        w_estado_nxt = r_estado;
        w_dose_nxt   = r_dose;
        w_unid_nxt   = r_unidades;
        w_usar_nxt   = 1'b0;
        w_refill_nxt = 1'b0;
        w_pronto_nxt = 1'b0;
        w_erro_nxt   = 1'b0;
        w_tmr_load   = 1'b0;
        w_tmr_value  = '0;

        unique case (r_estado)
            IDLE: begin
                if (w_req_valid) begin
                    w_dose_nxt   = w_req_longo ? C_LONGO : C_CURTO;
                    w_unid_nxt   = '0;
                    w_estado_nxt = CHECK;
                end
            end

            CHECK: begin
                if (bus.TempoDeAgua >= r_dose) begin
                    w_usar_nxt   = 1'b1;
                    w_estado_nxt = POUR;
                end else begin
                    w_refill_nxt = 1'b1;
                    w_tmr_load   = 1'b1;
                    w_tmr_value  = C_HOLD_LOAD;
                    w_estado_nxt = REFILL_REQ;
                end
            end

            // r_unidades counts units whose Usar cycle has completed, so it
            // trails Usar by one cycle and reaches the dose as Usar drops.
            POUR: begin
                if (!bus.TemAgua && (r_unidades < r_dose)) begin
                    w_erro_nxt   = 1'b1;
                    w_unid_nxt   = '0;
                    w_dose_nxt   = '0;
                    w_estado_nxt = IDLE;
                end else begin
                    w_unid_nxt = w_unid_inc;
                    if (w_unid_inc == r_dose) begin
                        w_pronto_nxt = 1'b1;
                        w_estado_nxt = DONE;
                    end else begin
                        w_usar_nxt = 1'b1;
                    end
                end
            end

            DONE: begin
                w_estado_nxt = IDLE;
            end

            REFILL_REQ: begin
                if (w_tmr_zero) begin
                    // Refill falls here; the reservoir reloads on that edge.
                    w_tmr_load   = 1'b1;
                    w_tmr_value  = C_TMO_LOAD;
                    w_estado_nxt = REFILL_WAIT;
                end else begin
                    w_refill_nxt = 1'b1;
                end
            end

            // Confirmation is tested before the timeout so a late confirm wins.
            REFILL_WAIT: begin
                if (bus.HouveRefill || (bus.TempoDeAgua == C_CAP)) begin
                    w_unid_nxt   = '0;
                    w_estado_nxt = CHECK;
                end else if (w_tmr_zero) begin
                    w_erro_nxt   = 1'b1;
                    w_dose_nxt   = '0;
                    w_estado_nxt = IDLE;
                end
            end

            default: begin
                w_estado_nxt = IDLE;
            end
        endcase

        w_ocupado_nxt = (w_estado_nxt != IDLE);
    end

    assign bus.Usar             = r_usar;
    assign bus.Refill           = r_refill;
    assign bus.Ocupado          = r_ocupado;
    assign bus.Pronto           = r_pronto;
    assign bus.Erro             = r_erro;
    assign bus.UnidadesServidas = r_unidades;

endmodule

// File: tb/tb_dispensador_agua.sv
// tb/tb_dispensador_agua.sv - self-checking bench for dispensador_agua with a reservoir model
module tb_dispensador_agua;
    import maquina_cafe_pkg::*;

    localparam int CAP  = AGUA_CAPACIDADE;
    localparam int D_C  = AGUA_DOSE_CURTO;
    localparam int D_L  = AGUA_DOSE_LONGO;
    localparam int HOLD = 2;
    localparam int TMO  = 8;

    logic Clock = 1'b0;
    logic Reset = 1'b1;

    dispensador_agua_if bus();

    dispensador_agua #(
        .CAPACIDADE     (CAP),
        .DOSE_CURTO     (D_C),
        .DOSE_LONGO     (D_L),
        .REFILL_HOLD    (HOLD),
        .REFILL_TIMEOUT (TMO)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;

    logic req_c      = 1'b0;
    logic req_l      = 1'b0;
    logic lvl_load   = 1'b0;
    logic refill_en  = 1'b1;
    logic force_seco = 1'b0;
    int   lvl_val    = 0;

    // Reservoir: one unit per Usar cycle, reload on Refill falling edge.
    int   lvl      = CAP;
    logic houve    = 1'b0;
    logic refill_d = 1'b0;

    always @(posedge Clock) begin
        refill_d <= bus.Refill;
        houve    <= 1'b0;
        if (lvl_load) begin
            lvl <= lvl_val;
        end else if (refill_d && !bus.Refill && refill_en) begin
            lvl   <= CAP;
            houve <= 1'b1;
        end else if (bus.Usar && lvl != 0) begin
            lvl <= lvl - 1;
        end
    end

    assign bus.PedidoCurto = req_c;
    assign bus.PedidoLongo = req_l;
    assign bus.TempoDeAgua = AGUA_NIVEL_W'(lvl);
    assign bus.TemAgua     = (lvl != 0) && !force_seco;
    assign bus.HouveRefill = houve;

    // Event monitor, sampled mid-cycle.
    int   cyc = 0, n_usar = 0, n_rhi = 0, n_rpul = 0, n_pronto = 0, n_erro = 0;
    int   last_usar_cyc = 0, last_refill_cyc = 0, pronto_cyc = 0, erro_cyc = 0;
    int   unid_pronto = 0, unid_erro = 0;
    logic refill_prev = 1'b0;

    always @(negedge Clock) begin
        cyc         <= cyc + 1;
        refill_prev <= bus.Refill;
        if (bus.Usar) begin
            n_usar        <= n_usar + 1;
            last_usar_cyc <= cyc;
        end
        if (bus.Refill) begin
            n_rhi           <= n_rhi + 1;
            last_refill_cyc <= cyc;
            if (!refill_prev) n_rpul <= n_rpul + 1;
        end
        if (bus.Pronto) begin
            n_pronto    <= n_pronto + 1;
            pronto_cyc  <= cyc;
            unid_pronto <= int'(bus.UnidadesServidas);
        end
        if (bus.Erro) begin
            n_erro    <= n_erro + 1;
            erro_cyc  <= cyc;
            unid_erro <= int'(bus.UnidadesServidas);
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    int d_usar, d_rhi, d_rpul, d_pronto, d_erro, d_tmo;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One drink transaction: set level, pulse request, run until idle settles.
    task automatic drink(input logic c, input logic l, input int lvl0, input logic ren,
                         input logic extra_l, input logic seco);
        int   b_usar, b_rhi, b_rpul, b_pr, b_er, idle_run;
        logic inj;
        @(negedge Clock);
        lvl_load  = 1'b1;
        lvl_val   = lvl0;
        refill_en = ren;
        @(negedge Clock);
        lvl_load = 1'b0;
        b_usar = n_usar; b_rhi = n_rhi; b_rpul = n_rpul; b_pr = n_pronto; b_er = n_erro;
        req_c = c;
        req_l = l;
        @(negedge Clock);
        req_c    = 1'b0;
        req_l    = 1'b0;
        idle_run = 0;
        inj      = 1'b0;
        for (int k = 0; k < 300 && idle_run < 3; k++) begin
            @(negedge Clock);
            req_l = 1'b0;
            if (extra_l && !inj && bus.Usar) begin
                req_l = 1'b1;
                inj   = 1'b1;
            end
            if (seco && bus.Usar) force_seco = 1'b1;
            idle_run = bus.Ocupado ? 0 : idle_run + 1;
        end
        force_seco = 1'b0;
        d_tmo    = (idle_run < 3) ? 1 : 0;
        d_usar   = n_usar - b_usar;
        d_rhi    = n_rhi - b_rhi;
        d_rpul   = n_rpul - b_rpul;
        d_pronto = n_pronto - b_pr;
        d_erro   = n_erro - b_er;
    endtask

    // Transaction-level reference: what a single request must produce.
    function automatic void modelo(input logic c, input logic l, input int lvl0, input logic ren,
                                   output int e_usar, output int e_pr, output int e_er,
                                   output int e_rpul, output int e_lvl);
        int dose;
        dose = c ? D_C : (l ? D_L : 0);
        if (lvl0 >= dose) begin
            e_usar = dose; e_pr = 1; e_er = 0; e_rpul = 0; e_lvl = lvl0 - dose;
        end else if (ren) begin
            e_usar = dose; e_pr = 1; e_er = 0; e_rpul = 1; e_lvl = CAP - dose;
        end else begin
            e_usar = 0; e_pr = 0; e_er = 1; e_rpul = 1; e_lvl = lvl0;
        end
    endfunction

    task automatic check_std(input string tag, input logic c, input logic l,
                             input int lvl0, input logic ren);
        int e_usar, e_pr, e_er, e_rpul, e_lvl;
        modelo(c, l, lvl0, ren, e_usar, e_pr, e_er, e_rpul, e_lvl);
        chk({tag, ":timeout"}, d_tmo, 0);
        chk({tag, ":usar_cycles"}, d_usar, e_usar);
        chk({tag, ":pronto"}, d_pronto, e_pr);
        chk({tag, ":erro"}, d_erro, e_er);
        chk({tag, ":refill_pulses"}, d_rpul, e_rpul);
        chk({tag, ":refill_high"}, d_rhi, e_rpul * HOLD);
        chk({tag, ":level"}, lvl, e_lvl);
        if (e_pr == 1) chk({tag, ":units"}, unid_pronto, e_usar);
        chk({tag, ":ocupado_end"}, bus.Ocupado, 0);
    endtask

    initial begin
        int   sel, lvl0;
        logic c, l, ren;

        Reset = 1'b1;
        repeat (3) @(negedge Clock);
        chk("reset:usar", bus.Usar, 0);
        chk("reset:refill", bus.Refill, 0);
        chk("reset:ocupado", bus.Ocupado, 0);
        chk("reset:pronto", bus.Pronto, 0);
        chk("reset:erro", bus.Erro, 0);
        chk("reset:units", bus.UnidadesServidas, 0);
        Reset = 1'b0;

        drink(1'b1, 1'b0, 10, 1'b1, 1'b0, 1'b0);
        check_std("curto_l10", 1'b1, 1'b0, 10, 1'b1);
        chk("curto_l10:pronto_after_usar", pronto_cyc - last_usar_cyc, 1);

        drink(1'b0, 1'b1, 3, 1'b1, 1'b0, 1'b0);
        check_std("longo_refill", 1'b0, 1'b1, 3, 1'b1);

        drink(1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0);
        check_std("longo_no_refill", 1'b0, 1'b1, 1, 1'b0);
        chk("longo_no_refill:erro_latency", erro_cyc - (last_refill_cyc + 1), TMO);

        drink(1'b1, 1'b1, 10, 1'b1, 1'b0, 1'b0);
        check_std("both_requests", 1'b1, 1'b1, 10, 1'b1);

        drink(1'b1, 1'b0, 10, 1'b1, 1'b1, 1'b0);
        chk("busy_longo:timeout", d_tmo, 0);
`ifdef PEDIDO_FILA_EN
        chk("busy_longo:usar_cycles", d_usar, D_C + D_L);
        chk("busy_longo:pronto", d_pronto, 2);
        chk("busy_longo:level", lvl, CAP - D_C - D_L);
`else
        chk("busy_longo:usar_cycles", d_usar, D_C);
        chk("busy_longo:pronto", d_pronto, 1);
        chk("busy_longo:level", lvl, CAP - D_C);
`endif

        @(negedge Clock);
        lvl_load = 1'b1;
        lvl_val  = 10;
        @(negedge Clock);
        lvl_load = 1'b0;
        req_c    = 1'b1;
        @(negedge Clock);
        req_c = 1'b0;
        for (int k = 0; k < 20 && !bus.Usar; k++) @(negedge Clock);
        chk("rst_mid:usar_before", bus.Usar, 1);
        Reset = 1'b1;
        #1;
        chk("rst_mid:usar", bus.Usar, 0);
        chk("rst_mid:ocupado", bus.Ocupado, 0);
        chk("rst_mid:units", bus.UnidadesServidas, 0);
        @(negedge Clock);
        Reset = 1'b0;
        drink(1'b1, 1'b0, 10, 1'b1, 1'b0, 1'b0);
        check_std("after_reset", 1'b1, 1'b0, 10, 1'b1);

        drink(1'b0, 1'b1, 10, 1'b1, 1'b0, 1'b1);
        chk("seco:timeout", d_tmo, 0);
        chk("seco:usar_cycles", d_usar, 1);
        chk("seco:erro", d_erro, 1);
        chk("seco:pronto", d_pronto, 0);
        chk("seco:units_at_erro", unid_erro, 0);
        chk("seco:level", lvl, CAP - 1);
        chk("seco:ocupado_end", bus.Ocupado, 0);

        for (int i = 0; i < 24; i++) begin
            sel  = int'($urandom_range(0, 2));
            lvl0 = int'($urandom_range(0, CAP));
            ren  = ($urandom_range(0, 1) == 1);
            c    = (sel != 1);
            l    = (sel != 0);
            drink(c, l, lvl0, ren, 1'b0, 1'b0);
            check_std("random", c, l, lvl0, ren);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
